// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scanner: rotates through DIGITS slots, blanks the start of each
// slot against ghosting, and double-buffers display contents so updates land on frame wrap.
module seg_scan_mux #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 16,
  parameter int unsigned HEX_MODE    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   num_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  load,
  output logic                  load_ack,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            dsp,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int unsigned DW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam logic [DW-1:0] DivLast  = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] BlankEnd = DW'(BLANK_CYC);
  localparam logic [IW-1:0] IdxLast  = IW'(DIGITS - 1);

  logic [DW-1:0]         r_div;
  logic [IW-1:0]         r_idx;
  logic                  r_pending;
  logic [4*DIGITS-1:0]   r_num;
  logic [DIGITS-1:0]     r_dp;
  logic [DIGITS-1:0]     r_blank;
  logic [DIGITS-1:0]     r_an;
  logic [6:0]            r_dsp;
  logic                  r_dp_out;

  logic                  w_slot_end;
  logic                  w_wrap;
  logic                  w_capture;
  logic [3:0]            w_digit;
  logic [DIGITS-1:0]     w_an_d;
  logic [6:0]            w_dsp_d;
  logic                  w_dp_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      4'd10:   seg = (HEX_MODE != 0) ? 7'b0001000 : 7'b0111111;
      4'd11:   seg = (HEX_MODE != 0) ? 7'b0000011 : 7'b0111111;
      4'd12:   seg = (HEX_MODE != 0) ? 7'b1000110 : 7'b0111111;
      4'd13:   seg = (HEX_MODE != 0) ? 7'b0100001 : 7'b0111111;
      4'd14:   seg = (HEX_MODE != 0) ? 7'b0000110 : 7'b0111111;
      default: seg = (HEX_MODE != 0) ? 7'b0001110 : 7'b0111111;
    endcase
    return seg;
  endfunction

  assign w_slot_end = (r_div == DivLast);
  assign w_wrap     = w_slot_end && (r_idx == IdxLast);
  // A load arriving on the wrap cycle itself is taken without waiting a frame.
  assign w_capture  = w_wrap && (r_pending || load);
  assign w_digit    = r_num[4*r_idx +: 4];

  assign frame_tick = w_wrap;
  assign load_ack   = w_capture;
  assign an         = r_an;
  assign dsp        = r_dsp;
  assign dp         = r_dp_out;

  always_comb begin
    w_an_d  = '1;
    w_dsp_d = 7'h7f;
    w_dp_d  = 1'b1;
    if (!(r_div < BlankEnd) && !r_blank[r_idx]) begin
      w_an_d[r_idx] = 1'b0;
      w_dsp_d       = seg_decode(w_digit);
      w_dp_d        = ~r_dp[r_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_num     <= '0;
      r_dp      <= '0;
      r_blank   <= '1;
      r_an      <= '1;
      r_dsp     <= 7'h7f;
      r_dp_out  <= 1'b1;
    end else begin
      if (w_slot_end) begin
        r_div <= '0;
        r_idx <= w_wrap ? '0 : r_idx + 1'b1;
      end else begin
        r_div <= r_div + 1'b1;
      end

      if (w_capture) begin
        r_pending <= 1'b0;
        r_num     <= num_in;
        r_dp      <= dp_in;
        r_blank   <= blank_in;
      end else if (load) begin
        r_pending <= 1'b1;
      end

      r_an     <= w_an_d;
      r_dsp    <= w_dsp_d;
      r_dp_out <= w_dp_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: table of display vectors checked slot by slot on a hex
// and a dash-mode instance, plus hand sequences for load merging, wrap-cycle load and reset.
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] num_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        load;
  logic        load_ack, frame_tick, dp;
  logic [3:0]  an;
  logic [6:0]  dsp;
  logic        load_ack_d, frame_tick_d, dp_d;
  logic [3:0]  an_d;
  logic [6:0]  dsp_d;

  int n_vec = 0;
  int n_bad = 0;
  int ack_cnt = 0;

  always #5 clk = ~clk;

  seg_scan_mux #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(1), .HEX_MODE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .num_in(num_in), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .load_ack(load_ack), .an(an), .dsp(dsp), .dp(dp), .frame_tick(frame_tick)
  );

  seg_scan_mux #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(1), .HEX_MODE(0)) u_dut_dash (
    .clk(clk), .rst_n(rst_n), .num_in(num_in), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .load_ack(load_ack_d), .an(an_d), .dsp(dsp_d), .dp(dp_d),
    .frame_tick(frame_tick_d)
  );

  always @(negedge clk) if (load_ack) ack_cnt++;

  typedef struct packed {
    logic [15:0]     num;
    logic [3:0]      dpi;
    logic [3:0]      blk;
    logic [3:0][6:0] hex;
    logic [3:0][6:0] dash;
    logic [3:0]      dpn;
  } vec_t;

  vec_t vt[5];
  vec_t vb, vc;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_frame(input vec_t v);
    logic [3:0] ea;
    logic [6:0] eh, ed;
    logic       ep;
    int         k;
    @(posedge clk); #1;
    load = 1'b0;
    num_in = ~v.num;
    dp_in = ~v.dpi;
    blank_in = 4'h0;
    @(negedge clk);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      k = j / 4;
      if ((j % 4) == 0 || v.blk[k]) begin
        ea = 4'hF; eh = 7'h7f; ed = 7'h7f; ep = 1'b1;
      end else begin
        ea = ~(4'b1 << k); eh = v.hex[k]; ed = v.dash[k]; ep = v.dpn[k];
      end
      chk("frame_hex", {an, dsp, dp}, {ea, eh, ep});
      chk("frame_dash", {an_d, dsp_d, dp_d}, {ea, ed, ep});
    end
  endtask

  task automatic apply_vec(input vec_t v);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    num_in = v.num; dp_in = v.dpi; blank_in = v.blk; load = 1'b1;
    for (int i = 0; i < 48 && !got; i++) begin
      @(negedge clk);
      if (load_ack) begin
        got = 1'b1;
        chk("ack_at_wrap", {11'b0, frame_tick}, 12'd1);
        chk("ack_dash", {11'b0, load_ack_d}, 12'd1);
      end else begin
        @(posedge clk); #1;
        load = 1'b0;
      end
    end
    chk("ack_seen", {11'b0, got}, 12'd1);
    check_frame(v);
  endtask

  task automatic wait_tick();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (frame_tick) got = 1'b1;
    end
    chk("tick_seen", {11'b0, got}, 12'd1);
  endtask

  int a0;

  initial begin
    vt[0] = '{num: 16'h4321, dpi: 4'b0010, blk: 4'b0000,
              hex:  {7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001},
              dash: {7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}, dpn: 4'b1101};
    vt[1] = '{num: 16'hFA09, dpi: 4'b0000, blk: 4'b0000,
              hex:  {7'b0001110, 7'b0001000, 7'b1000000, 7'b0010000},
              dash: {7'b0111111, 7'b0111111, 7'b1000000, 7'b0010000}, dpn: 4'b1111};
    vt[2] = '{num: 16'h8765, dpi: 4'b1111, blk: 4'b0100,
              hex:  {7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010},
              dash: {7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010}, dpn: 4'b0000};
    vt[3] = '{num: 16'hEDCB, dpi: 4'b1000, blk: 4'b0000,
              hex:  {7'b0000110, 7'b0100001, 7'b1000110, 7'b0000011},
              dash: {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}, dpn: 4'b0111};
    vt[4] = '{num: 16'h0000, dpi: 4'b1111, blk: 4'b1111,
              hex:  {4{7'b1000000}}, dash: {4{7'b1000000}}, dpn: 4'b0000};
    vb = '{num: 16'h9876, dpi: 4'b0000, blk: 4'b0000,
           hex:  {7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010},
           dash: {7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010}, dpn: 4'b1111};
    vc = '{num: 16'h5A5A, dpi: 4'b0101, blk: 4'b0000,
           hex:  {7'b0010010, 7'b0001000, 7'b0010010, 7'b0001000},
           dash: {7'b0010010, 7'b0111111, 7'b0010010, 7'b0111111}, dpn: 4'b1010};

    rst_n = 1'b0; num_in = '0; dp_in = '0; blank_in = '0; load = 1'b0;
    @(negedge clk);
    chk("reset_out", {an, dsp, dp}, 12'hFFF);
    chk("reset_pulses", {10'b0, load_ack, frame_tick}, 12'd0);

    // Idle after reset: dark, frame_tick on every 16th cycle.
    @(posedge clk); #1 rst_n = 1'b1;
    for (int m = 0; m < 40; m++) begin
      @(negedge clk);
      chk("idle_tick", {11'b0, frame_tick}, {11'b0, ((m % 16) == 15)});
      chk("idle_dark", {8'b0, an}, 12'h00F);
    end

    for (int i = 0; i < 3; i++) apply_vec(vt[i]);

    // Several loads mid-frame merge into one capture of the wrap-cycle value.
    wait_tick();
    a0 = ack_cnt;
    @(posedge clk); #1 load = 1'b1; num_in = 16'h1111; dp_in = '0; blank_in = '0;
    @(posedge clk); #1 load = 1'b0;
    repeat (3) @(posedge clk);
    #1 load = 1'b1; num_in = 16'h2222;
    @(posedge clk); #1 load = 1'b0;
    @(posedge clk); #1 load = 1'b1; num_in = 16'h3333;
    @(posedge clk); #1 load = 1'b0; num_in = 16'h9876;
    chk("no_early_ack", ack_cnt[11:0], a0[11:0]);
    begin
      logic got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (load_ack) got = 1'b1;
      end
      chk("merged_ack", {10'b0, got, frame_tick}, 12'd3);
    end
    check_frame(vb);
    @(posedge clk); #1;
    chk("single_ack", ack_cnt[11:0], a0[11:0] + 12'd1);

    // Load exactly on the wrap cycle: acknowledged in that same cycle.
    wait_tick();
    repeat (16) @(posedge clk);
    #1 num_in = vc.num; dp_in = vc.dpi; blank_in = vc.blk; load = 1'b1;
    @(negedge clk);
    chk("wrap_load_ack", {10'b0, load_ack, frame_tick}, 12'd3);
    check_frame(vc);

    // Reset with a load pending: dark at once, never acknowledged.
    wait_tick();
    @(posedge clk); #1 load = 1'b1; num_in = 16'h1234;
    @(posedge clk); #1 load = 1'b0;
    a0 = ack_cnt;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_dark", {an, dsp, dp}, 12'hFFF);
    chk("rst_dark_dash", {an_d, dsp_d, dp_d}, 12'hFFF);
    chk("rst_no_ack", {11'b0, load_ack}, 12'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int m = 0; m < 40; m++) begin
      @(negedge clk);
      chk("post_rst_idle", {7'b0, load_ack, an}, 12'h00F);
    end
    @(posedge clk); #1;
    chk("lost_load", ack_cnt[11:0], a0[11:0]);

    apply_vec(vt[3]);
    apply_vec(vt[4]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
